// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared constants and state encoding for the shift-add multiplier
package multiplier_pkg;

  // Default operand/result width and the matching bit-counter width
  localparam int WIDTH = 10;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALC      = 2'd1,
    DONE      = 2'd2,
    ZERO_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/multiplier_datapath.sv
// rtl/multiplier_datapath.sv - operand, accumulator, counter and result registers for shift-add multiply
module multiplier_datapath #(
  parameter int WIDTH = multiplier_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sclr_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] ain_i,
  input  logic [WIDTH-1:0] bin_i,
  output logic             ops_zero_o,
  output logic             cnt_zero_o,
  output logic [WIDTH-1:0] pout_o,
  output logic             ovf_o,
  output logic             zro_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   mplier_d;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   pout_q;
  logic               ovf_q;
  logic               zro_q;

  // One shift-add step: conditional add into the upper half (with carry), then shift right
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_d    = {sum, acc_q[WIDTH-1:1]};
    mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
  end

  assign ops_zero_o = (ain_i == '0) || (bin_i == '0);
  assign cnt_zero_o = (cnt_q == '0);
  assign pout_o     = pout_q;
  assign ovf_o      = ovf_q;
  assign zro_o      = zro_q;

  // Capture operands on load, iterate on step; results latch on the final step and hold afterwards
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      pout_q   <= '0;
      ovf_q    <= 1'b0;
      zro_q    <= 1'b0;
    end else if (sclr_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      pout_q   <= '0;
      ovf_q    <= 1'b0;
      zro_q    <= 1'b0;
    end else if (load_i) begin
      mcand_q  <= ain_i;
      mplier_q <= bin_i;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH - 1);
      pout_q   <= '0;
      ovf_q    <= 1'b0;
      zro_q    <= ops_zero_o;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      if (!cnt_zero_o) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        pout_q <= acc_d[WIDTH-1:0];
        ovf_q  <= |acc_d[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: rtl/multiplier.sv
// rtl/multiplier.sv - sequential unsigned multiplier, FSM control around the shift-add datapath
module multiplier #(
  parameter int WIDTH = multiplier_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCLR,
  input  logic [WIDTH-1:0] AIN,
  input  logic [WIDTH-1:0] BIN,
  input  logic             START,
  output logic [WIDTH-1:0] POUT,
  output logic             OVF,
  output logic             ZRO,
  output logic             BUSY,
  output logic             VALID
);

  import multiplier_pkg::*;

  state_e state_q;
  state_e state_d;
  logic   load;
  logic   step;
  logic   ops_zero;
  logic   cnt_zero;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; synchronous clear overrides any request
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          load    = 1'b1;
          state_d = ops_zero ? ZERO_DONE : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_zero) begin
          state_d = DONE;
        end
      end
      DONE:      state_d = IDLE;
      ZERO_DONE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (SCLR) begin
      state_d = IDLE;
      load    = 1'b0;
      step    = 1'b0;
    end
  end

  assign BUSY  = (state_q != IDLE);
  assign VALID = (state_q == DONE) || (state_q == ZERO_DONE);

  multiplier_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .CLK        (CLK),
    .RST        (RST),
    .sclr_i     (SCLR),
    .load_i     (load),
    .step_i     (step),
    .ain_i      (AIN),
    .bin_i      (BIN),
    .ops_zero_o (ops_zero),
    .cnt_zero_o (cnt_zero),
    .pout_o     (POUT),
    .ovf_o      (OVF),
    .zro_o      (ZRO)
  );

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - scoreboard bench for the shift-add multiplier
module tb_multiplier;

  localparam int W = 10;

  typedef struct packed {
    logic [W-1:0] p;
    logic         o;
    logic         z;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic         SCLR;
  logic         START;
  logic [W-1:0] AIN;
  logic [W-1:0] BIN;
  logic [W-1:0] POUT;
  logic         OVF;
  logic         ZRO;
  logic         BUSY;
  logic         VALID;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   valids = 0;
  int   pushed = 0;

  multiplier #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .SCLR  (SCLR),
    .AIN   (AIN),
    .BIN   (BIN),
    .START (START),
    .POUT  (POUT),
    .OVF   (OVF),
    .ZRO   (ZRO),
    .BUSY  (BUSY),
    .VALID (VALID)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] full;
    exp_t e;
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    e.p  = full[W-1:0];
    e.o  = |full[2*W-1:W];
    e.z  = (a == '0) || (b == '0);
    return e;
  endfunction

  // Scoreboard: every VALID pulse pops one expected result
  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      valids++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("pout", POUT, mon_e.p);
        check("ovf", OVF, mon_e.o);
        check("zro", ZRO, mon_e.z);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(posedge CLK);
    #1;
    AIN   = a;
    BIN   = b;
    START = 1'b1;
    if (push) begin
      exp_q.push_back(model(a, b));
      pushed++;
    end
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat, input bit disturb);
    int n  = 0;
    int nb = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b1) nb++;
      if (disturb && i == 3) begin
        AIN   = 10'd5;
        BIN   = 10'd7;
        START = 1'b1;
      end
      if (disturb && i == 4) START = 1'b0;
      if (VALID === 1'b1) begin
        n = i;
        break;
      end
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_cycles"}, nb, exp_lat);
    @(negedge CLK);
    check({tag, "_valid_one_cycle"}, VALID, 0);
    check({tag, "_idle_busy"}, BUSY, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] vv;
    logic [4:0] bv;
    RST   = 1'b1;
    SCLR  = 1'b0;
    START = 1'b0;
    AIN   = '0;
    BIN   = '0;
    #3;
    check("rst_pout", POUT, 0);
    check("rst_ovf", OVF, 0);
    check("rst_zro", ZRO, 0);
    check("rst_busy", BUSY, 0);
    check("rst_valid", VALID, 0);
    #20 RST = 1'b0;

    // Normal, overflow and boundary products
    start_op(10'd13, 10'd11, 1);
    wait_valid("norm", 11, 0);
    @(negedge CLK);
    @(negedge CLK);
    check("hold_pout", POUT, 143);
    check("hold_zro", ZRO, 0);
    start_op(10'd1023, 10'd1023, 1);
    wait_valid("ovf_max", 11, 0);
    check("hold_ovf", OVF, 1);
    start_op(10'd32, 10'd32, 1);
    wait_valid("ovf_edge", 11, 0);
    start_op(10'd31, 10'd33, 1);
    wait_valid("no_ovf_edge", 11, 0);
    check("hold_pout_1023", POUT, 1023);

    // Zero operands take the short path
    start_op(10'd0, 10'd517, 1);
    wait_valid("zero_a", 1, 0);
    start_op(10'd517, 10'd0, 1);
    wait_valid("zero_b", 1, 0);
    check("hold_zro_set", ZRO, 1);

    // START and operand changes during CALC are ignored
    start_op(10'd13, 10'd11, 1);
    wait_valid("ignore", 11, 0 | 1);

    // START held high: back-to-back operations with one idle cycle between
    @(posedge CLK);
    #1;
    AIN   = 10'd0;
    BIN   = 10'd3;
    START = 1'b1;
    exp_q.push_back(model(10'd0, 10'd3));
    exp_q.push_back(model(10'd0, 10'd3));
    pushed += 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      vv[i] = VALID;
      bv[i] = BUSY;
      if (i == 3) START = 1'b0;
    end
    check("b2b_valid", vv, 5'b01010);
    check("b2b_busy", bv, 5'b01010);

    // Asynchronous reset in the middle of CALC
    start_op(10'd13, 10'd11, 0);
    repeat (5) @(negedge CLK);
    check("pre_rst_busy", BUSY, 1);
    #2 RST = 1'b1;
    #1;
    check("abort_rst_busy", BUSY, 0);
    check("abort_rst_valid", VALID, 0);
    check("abort_rst_pout", POUT, 0);
    check("abort_rst_zro", ZRO, 0);
    #1 RST = 1'b0;
    repeat (15) @(negedge CLK);
    start_op(10'd6, 10'd7, 1);
    wait_valid("after_rst", 11, 0);
    check("after_rst_pout", POUT, 42);

    // Synchronous clear in the middle of CALC
    start_op(10'd13, 10'd11, 0);
    repeat (5) @(negedge CLK);
    SCLR = 1'b1;
    #1;
    check("sclr_sync_busy", BUSY, 1);
    @(posedge CLK);
    #1;
    check("abort_sclr_busy", BUSY, 0);
    check("abort_sclr_valid", VALID, 0);
    check("abort_sclr_pout", POUT, 0);
    SCLR = 1'b0;
    repeat (15) @(negedge CLK);
    start_op(10'd6, 10'd7, 1);
    wait_valid("after_sclr", 11, 0);
    check("after_sclr_pout", POUT, 42);

    // SCLR wins over START in IDLE
    @(posedge CLK);
    #1;
    AIN   = 10'd3;
    BIN   = 10'd3;
    START = 1'b1;
    SCLR  = 1'b1;
    @(posedge CLK);
    #1;
    check("sclr_priority_busy", BUSY, 0);
    check("sclr_priority_pout", POUT, 0);
    START = 1'b0;
    SCLR  = 1'b0;

    repeat (3) @(negedge CLK);
    check("queue_empty", exp_q.size(), 0);
    check("valid_count", valids, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
